// File: rtl/mem_axi_bridge.sv
// Data-side AXI master for the MEM stage: posted stores tracked in an
// outstanding-write table, one in-flight load, read-after-write blocking.
module mem_axi_bridge #(
  parameter int              WT_DEPTH = 4,
  parameter int              ID_W     = 4,
  parameter logic [ID_W-1:0] RD_ID    = 4'd15
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_wr_i,
  input  logic [31:0]     req_addr_i,
  input  logic [2:0]      req_size_i,
  input  logic [3:0]      req_wstrb_i,
  input  logic [31:0]     req_wdata_i,
  output logic            rsp_valid_o,
  output logic [31:0]     rsp_rdata_o,
  input  logic            rsp_ready_i,
  output logic [3:0]      wr_outstanding_o,
  output logic [ID_W-1:0] axi_arid_o,
  output logic [31:0]     axi_araddr_o,
  output logic [2:0]      axi_arsize_o,
  output logic            axi_arvalid_o,
  input  logic            axi_arready_i,
  input  logic [ID_W-1:0] axi_rid_i,
  input  logic [31:0]     axi_rdata_i,
  input  logic            axi_rvalid_i,
  output logic            axi_rready_o,
  output logic [ID_W-1:0] axi_awid_o,
  output logic [31:0]     axi_awaddr_o,
  output logic [2:0]      axi_awsize_o,
  output logic            axi_awvalid_o,
  input  logic            axi_awready_i,
  output logic [ID_W-1:0] axi_wid_o,
  output logic [31:0]     axi_wdata_o,
  output logic [3:0]      axi_wstrb_o,
  output logic            axi_wvalid_o,
  input  logic            axi_wready_i,
  input  logic [ID_W-1:0] axi_bid_i,
  input  logic            axi_bvalid_i,
  output logic            axi_bready_o
);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_R    = 2'd2;
  localparam logic [1:0] R_RSP  = 2'd3;

  logic [WT_DEPTH-1:0] wt_valid_q, wt_valid_d;
  logic [29:0]         wt_addr_q [WT_DEPTH];
  logic [ID_W-1:0]     alloc_id;
  logic                alloc_found, hazard;
  logic [3:0]          outstanding;

  logic                awvalid_q, wvalid_q, bready_q;
  logic [ID_W-1:0]     awid_q, wid_q;
  logic [31:0]         awaddr_q, wdata_q;
  logic [2:0]          awsize_q;
  logic [3:0]          wstrb_q;

  logic [1:0]          state_q, state_d;
  logic [31:0]         araddr_q, araddr_d;
  logic [31:0]         rsp_rdata_q, rsp_rdata_d;
  logic                rsp_valid_q, rsp_valid_d;

  logic st_ok, ld_ok, st_fire, ld_fire;

  // Descending scan so the lowest free index is the one left standing.
  always_comb begin
    alloc_found = 1'b0;
    alloc_id    = '0;
    hazard      = 1'b0;
    outstanding = 4'd0;
    for (int i = WT_DEPTH - 1; i >= 0; i--) begin
      if (!wt_valid_q[i]) begin
        alloc_found = 1'b1;
        alloc_id    = ID_W'(i);
      end
    end
    for (int i = 0; i < WT_DEPTH; i++) begin
      if (wt_valid_q[i] && (wt_addr_q[i] == req_addr_i[31:2])) hazard = 1'b1;
      outstanding = outstanding + {3'b000, wt_valid_q[i]};
    end
  end

  assign st_ok       = alloc_found && !awvalid_q && !wvalid_q;
  assign ld_ok       = !hazard && ((state_q == R_IDLE) || ((state_q == R_RSP) && rsp_ready_i));
  assign req_ready_o = req_wr_i ? st_ok : ld_ok;
  assign st_fire     = req_valid_i && req_wr_i && st_ok;
  assign ld_fire     = req_valid_i && !req_wr_i && ld_ok;

  always_comb begin
    wt_valid_d = wt_valid_q;
    if (axi_bvalid_i && bready_q) begin
      for (int i = 0; i < WT_DEPTH; i++) begin
        if (axi_bid_i == ID_W'(i)) wt_valid_d[i] = 1'b0;
      end
    end
    if (st_fire) begin
      for (int i = 0; i < WT_DEPTH; i++) begin
        if (alloc_id == ID_W'(i)) wt_valid_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < WT_DEPTH; i++) begin
      if (st_fire && (alloc_id == ID_W'(i))) wt_addr_q[i] <= req_addr_i[31:2];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wt_valid_q <= '0;
      bready_q   <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      awid_q     <= '0;
      wid_q      <= '0;
      awaddr_q   <= '0;
      awsize_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      wt_valid_q <= wt_valid_d;
      bready_q   <= 1'b1;
      // Payload only loads when both channels are idle, so it is stable while either valid is up.
      if (st_fire) begin
        awvalid_q <= 1'b1;
        wvalid_q  <= 1'b1;
        awid_q    <= alloc_id;
        wid_q     <= alloc_id;
        awaddr_q  <= req_addr_i;
        awsize_q  <= req_size_i;
        wdata_q   <= req_wdata_i;
        wstrb_q   <= req_wstrb_i;
      end else begin
        if (awvalid_q && axi_awready_i) awvalid_q <= 1'b0;
        if (wvalid_q && axi_wready_i)   wvalid_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    araddr_d    = araddr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      R_IDLE: begin
        if (ld_fire) begin
          state_d  = R_AR;
          araddr_d = {req_addr_i[31:2], 2'b00};
        end
      end
      R_AR: begin
        if (axi_arready_i) state_d = R_R;
      end
      R_R: begin
        if (axi_rvalid_i && (axi_rid_i == RD_ID)) begin
          rsp_rdata_d = axi_rdata_i;
          rsp_valid_d = 1'b1;
          state_d     = R_RSP;
        end
      end
      R_RSP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = R_IDLE;
          if (ld_fire) begin
            state_d  = R_AR;
            araddr_d = {req_addr_i[31:2], 2'b00};
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= R_IDLE;
      araddr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      araddr_q    <= araddr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign wr_outstanding_o = outstanding;
  assign rsp_valid_o      = rsp_valid_q;
  assign rsp_rdata_o      = rsp_rdata_q;
  assign axi_arid_o       = RD_ID;
  assign axi_araddr_o     = araddr_q;
  assign axi_arsize_o     = 3'b010;
  assign axi_arvalid_o    = (state_q == R_AR);
  assign axi_rready_o     = (state_q == R_R);
  assign axi_awid_o       = awid_q;
  assign axi_awaddr_o     = awaddr_q;
  assign axi_awsize_o     = awsize_q;
  assign axi_awvalid_o    = awvalid_q;
  assign axi_wid_o        = wid_q;
  assign axi_wdata_o      = wdata_q;
  assign axi_wstrb_o      = wstrb_q;
  assign axi_wvalid_o     = wvalid_q;
  assign axi_bready_o     = bready_q;

endmodule
